// File: rtl/somador_multibyte_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | somador_multibyte_ctrl_if : request/result bus of the byte adder  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface somador_multibyte_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] soma;
  logic         cout;
  logic         f;
  logic         busy;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, soma, cout, f, busy
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, soma, cout, f, busy
  );
endinterface
`default_nettype wire

// File: rtl/somador_multibyte_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | somador_multibyte_ctrl : wide add/sub, one byte per cycle         |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module somador_multibyte_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  somador_multibyte_ctrl_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  soma_r;
  logic [IW-1:0] idx;
  logic          carry;
  logic          cout_r;
  logic          f_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic          busy_r;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [8:0]    slice;
  logic [7:0]    low7;

  assign a_byte = op_a[8*int'(idx) +: 8];
  assign b_byte = op_b[8*int'(idx) +: 8];
  assign slice  = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
  // bit 7 of the 7-bit partial sum is the carry entering the sign bit
  assign low7   = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'd0, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      soma_r      <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      cout_r      <= 1'b0;
      f_r         <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_a       <= bus.a;
            op_b       <= bus.op_sub ? ~bus.b : bus.b;
            carry      <= bus.op_sub;
            idx        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          soma_r[8*int'(idx) +: 8] <= slice[7:0];
          carry                    <= slice[8];
          idx                      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_r      <= slice[8];
            f_r         <= low7[7] ^ slice[8];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.soma      = soma_r;
  assign bus.cout      = cout_r;
  assign bus.f         = f_r;
  assign bus.busy      = busy_r;
endmodule
`default_nettype wire

// File: tb/tb_somador_multibyte_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_somador_multibyte_ctrl : bench for the byte-serial adder       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_somador_multibyte_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int NV     = 8;
  localparam int NRAND  = 1000;

  logic clk;
  logic rst_n;

  somador_multibyte_ctrl_if #(.NBYTES(NBYTES)) bus ();

  somador_multibyte_ctrl #(.NBYTES(NBYTES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t             tv[NV];
  logic [W+1:0]     sb[$];
  int               total = 0;
  int               bad   = 0;
  int               acc_cnt = 0;
  int               out_cnt = 0;

  task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // golden model: returns {cout, f, sum}
  function automatic logic [W+1:0] model(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         ov;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sub};
    ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], ov, full[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    case ($urandom % 8)
      0: r = '0;
      1: r = '1;
      2: r = {1'b1, {(W-1){1'b0}}};
      3: r = {1'b0, {(W-1){1'b1}}};
      default: for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = 8'($urandom);
    endcase
    return r;
  endfunction

  // scoreboard: push on accept, pop on result handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.op_sub, bus.a, bus.b));
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        chk("sb_pending", (W+2)'(sb.size() != 0), (W+2)'(1));
        if (sb.size() != 0) chk("sb_result", {bus.cout, bus.f, bus.soma}, sb.pop_front());
      end
    end
  end

  task automatic issue(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.op_sub   = sub;
    bus.a        = x;
    bus.b        = y;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 64);
    chk("accept", (W+2)'(bus.in_ready), (W+2)'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!bus.out_valid && k < 64) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int           lat;
    logic [W+1:0] exp_x;
    logic [W-1:0] exp_s;
    bit           pending;
    bit           took;
    int           sent;
    int           cyc;

    tv[0] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    tv[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tv[2] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    tv[3] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
    tv[4] = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
    tv[5] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tv[6] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    tv[7] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {bus.out_valid, bus.in_ready, bus.busy, bus.cout, bus.f}, 5'b01000);
    chk("rst_soma", bus.soma, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);

    // table-driven vectors with latency check
    for (int i = 0; i < NV; i++) begin
      issue(tv[i].sub, tv[i].a, tv[i].b);
      chk($sformatf("busy%0d", i), {bus.busy, bus.in_ready}, 2'b10);
      wait_valid(lat);
      chk($sformatf("lat%0d", i), lat, NBYTES);
      chk($sformatf("vec%0d", i), {bus.cout, bus.f, bus.soma}, {tv[i].c, tv[i].v, tv[i].s});
      consume();
    end

    // progressive byte writes and carry ripple
    issue(1'b0, 32'h11223344, 32'h11111111);
    wait_valid(lat);
    chk("pre_ripple", {bus.cout, bus.f, bus.soma}, {2'b00, 32'h22334455});
    consume();
    issue(1'b0, 32'hFFFFFFFF, 32'h00000001);
    exp_s = 32'h22334455;
    for (int k = 0; k < NBYTES; k++) begin
      @(posedge clk);
      #1;
      exp_s[8*k +: 8] = 8'h00;
      chk($sformatf("ripple_soma%0d", k), bus.soma, exp_s);
      chk($sformatf("ripple_cout%0d", k), bus.cout, (k == NBYTES - 1) ? 1 : 0);
    end
    chk("ripple_valid", bus.out_valid, 1);
    consume();

    // backpressure in DONE with a new request held throughout
    exp_x = model(1'b1, 32'h00001000, 32'h00002001);
    issue(1'b1, 32'h00001000, 32'h00002001);
    bus.in_valid = 1'b1;
    bus.op_sub   = 1'b0;
    bus.a        = 32'h0F0F0F0F;
    bus.b        = 32'h01010101;
    wait_valid(lat);
    chk("bp_lat", lat, NBYTES);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {bus.cout, bus.f, bus.soma}, exp_x);
      chk($sformatf("bp_flags%0d", k), {bus.out_valid, bus.in_ready}, 2'b10);
      @(posedge clk);
      #1;
    end
    consume();
    chk("gate_idle", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    @(posedge clk);
    #1;
    chk("gate_accept", {bus.in_ready, bus.busy}, 2'b01);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("gate_result", {bus.cout, bus.f, bus.soma}, {2'b00, 32'h10101010});
    consume();

    // reset during the second ADD cycle
    issue(1'b0, 32'h12345678, 32'h11111111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {bus.out_valid, bus.in_ready, bus.busy, bus.cout, bus.f}, 5'b01000);
    chk("abort_soma", bus.soma, '0);
    sb.delete();
    acc_cnt = out_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_nov%0d", k), bus.out_valid, 0);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    issue(1'b0, 32'h12345678, 32'h11111111);
    wait_valid(lat);
    chk("abort_lat", lat, NBYTES);
    chk("abort_redo", {bus.cout, bus.f, bus.soma}, {2'b00, 32'h23456789});
    consume();

    // random stream with stalls
    acc_cnt = 0;
    out_cnt = 0;
    pending = 1'b0;
    sent    = 0;
    cyc     = 0;
    while ((sent < NRAND || pending) && cyc < 40000) begin
      if (!pending && sent < NRAND && ($urandom % 4) != 0) begin
        pending      = 1'b1;
        sent++;
        bus.in_valid = 1'b1;
        bus.op_sub   = 1'($urandom % 2);
        bus.a        = rnd();
        bus.b        = rnd();
      end
      bus.out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (took) begin
        pending      = 1'b0;
        bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((out_cnt != acc_cnt || bus.busy) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("rand_accepted", acc_cnt, NRAND);
    chk("rand_completed", out_cnt, NRAND);
    chk("rand_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
